// File: rtl/ranperm_pkg.sv
// ranperm_pkg: shared types and helpers for the ranperm_scheduler slice.
//   state_t        : scheduler FSM states (CHECK exists only when RANPERM_CHECK_EN
//                    is defined).
//   idx_w(n)       : width of one permutation index, $clog2(n).
//   onehot_to_idx  : position of the set bit in a one-hot vector (up to 32 bits).
package ranperm_pkg;

`ifdef RANPERM_CHECK_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GEN    = 3'd2,
    ST_CHECK  = 3'd3,
    ST_STREAM = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GEN    = 3'd2,
    ST_STREAM = 3'd4
  } state_t;
`endif

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int onehot_to_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   [R-1:0]  : request vector
//   ptr   [PW-1:0] : index with highest priority this round
//   grant [R-1:0]  : one-hot winner (first set bit at or after ptr, wrapping), 0 if none
module rr_arbiter #(
  parameter int R  = 4,
  parameter int PW = 2
) (
  input  logic [R-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [R-1:0]  grant
);

  logic [R-1:0] hi_mask;
  logic [R-1:0] upper;
  logic [R-1:0] pick;

  // Requests at or above ptr win first; if none, wrap to the full vector.
  // The lowest set bit of the chosen vector is isolated with x & -x.
  always_comb begin
    hi_mask = ~((R'(1) << ptr) - R'(1));
    upper   = req & hi_mask;
    pick    = (upper != '0) ? upper : req;
    grant   = pick & (~pick + R'(1));
  end

endmodule

// File: rtl/ranperm_scheduler.sv
// ranperm_scheduler: shares one external random_index permutation generator
// among R requesters. Round-robin grant, generator restart per grant, then the
// N-entry permutation is streamed to the winner over valid/ready.
//
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   req[R-1:0]              : level requests, held until the stream completes
//   grant[R-1:0]            : one-hot requester being served, 0 when idle
//   idx_data/valid/last     : index stream to the granted requester
//   idx_ready[R-1:0]        : per-requester ready, only the granted bit is used
//   gen_reset, gen_enable   : generator control (gen_reset is high while in reset)
//   gen_rand_index, gen_done: generator result, entry k at [k*W +: W]
//   busy                    : FSM is not idle
//   perm_err                : one-cycle pulse when a permutation is rejected
//
// Build option: define RANPERM_CHECK_EN to verify every permutation (each index
// 0..N-1 present exactly once) before streaming; rejected ones are regenerated.
// Without it, perm_err is constant 0 and GEN goes straight to STREAM.
module ranperm_scheduler
  import ranperm_pkg::*;
#(
  parameter int N = 16,
  parameter int R = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [R-1:0]              req,
  output logic [R-1:0]              grant,
  output logic [$clog2(N)-1:0]      idx_data,
  output logic                      idx_valid,
  input  logic [R-1:0]              idx_ready,
  output logic                      idx_last,
  output logic                      gen_reset,
  output logic                      gen_enable,
  input  logic [N*$clog2(N)-1:0]    gen_rand_index,
  input  logic                      gen_done,
  output logic                      busy,
  output logic                      perm_err
);

  localparam int W  = idx_w(N);
  localparam int PW = (R > 1) ? $clog2(R) : 1;
  localparam logic [W-1:0] CNT_ONE  = W'(1);
  localparam logic [W-1:0] CNT_LAST = W'(N - 1);
`ifdef RANPERM_CHECK_EN
  localparam state_t AFTER_GEN = ST_CHECK;
`else
  localparam state_t AFTER_GEN = ST_STREAM;
`endif

  state_t          state;
  state_t          state_next;
  logic [R-1:0]    arb_grant;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gsel;
  logic [PW-1:0]   ptr_after;
  logic [W-1:0]    cnt;
  logic [N*W-1:0]  perm_reg;
  logic            req_held;
  logic            abort;
  logic            hs;
  logic            at_last;
  logic            all_seen;

  rr_arbiter #(.R(R), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  assign gsel      = PW'(onehot_to_idx(32'(grant)));
  assign ptr_after = (gsel == PW'(R - 1)) ? '0 : gsel + PW'(1);
  // Only the granted requester's level matters once a grant is out.
  assign req_held  = |(req & grant);
  assign abort     = (state != ST_IDLE) && !req_held;
  assign hs        = (state == ST_STREAM) && idx_ready[gsel];
  assign at_last   = (cnt == CNT_LAST);

`ifdef RANPERM_CHECK_EN
  logic [N-1:0] seen;

  // Seen-map: a valid permutation sets every bit exactly once.
  always_comb begin
    seen = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(perm_reg[k*W +: W]) < N) seen[perm_reg[k*W +: W]] = 1'b1;
    end
  end
  assign all_seen = &seen;
`else
  assign all_seen = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (|req) state_next = ST_CLEAR;
      ST_CLEAR:  state_next = abort ? ST_IDLE : ST_GEN;
      ST_GEN: begin
        if (abort)         state_next = ST_IDLE;
        else if (gen_done) state_next = AFTER_GEN;
      end
`ifdef RANPERM_CHECK_EN
      ST_CHECK: begin
        if (abort)         state_next = ST_IDLE;
        else if (all_seen) state_next = ST_STREAM;
        else               state_next = ST_CLEAR;
      end
`endif
      ST_STREAM: if (abort || (hs && at_last)) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    gen_enable = (state == ST_GEN);
    idx_valid  = (state == ST_STREAM);
    idx_data   = idx_valid ? perm_reg[cnt*W +: W] : '0;
    idx_last   = idx_valid && at_last;
    busy       = (state != ST_IDLE);
`ifdef RANPERM_CHECK_EN
    perm_err   = (state == ST_CHECK) && !all_seen;
`else
    perm_err   = 1'b0;
`endif
  end

  // gen_reset is registered so it is high exactly for the cycles spent in CLEAR
  // and stays high while reset_n holds the block in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant     <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      perm_reg  <= '0;
      gen_reset <= 1'b1;
    end else begin
      gen_reset <= (state_next == ST_CLEAR);
      if (state == ST_IDLE) begin
        if (|req) grant <= arb_grant;
      end else if (state_next == ST_IDLE) begin
        // Completion and abort both move priority past the served requester.
        grant  <= '0;
        rr_ptr <= ptr_after;
      end
      if (state == ST_GEN && gen_done) begin
        perm_reg <= gen_rand_index;
        cnt      <= '0;
      end else if (hs) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ranperm_scheduler.sv
// Testbench for ranperm_scheduler: table-driven transactions, an abort, a
// reset during streaming, and randomized requests/ready checked against a
// round-robin reference and a behavioural permutation generator model.
module tb_ranperm_scheduler;

  localparam int N = 16;
  localparam int R = 4;
  localparam int W = $clog2(N);
`ifdef RANPERM_CHECK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int M_HIGH = 0, M_TOGGLE = 1, M_RAND = 2;
  localparam int K_NONE = 0, K_DROP = 1, K_RESET = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic [R-1:0] req, grant, idx_ready;
  logic [W-1:0] idx_data;
  logic idx_valid, idx_last, gen_reset, gen_enable, gen_done, busy, perm_err;
  logic [N*W-1:0] gen_rand_index;
  logic [N*W-1:0] gen_perm;

  int checks, failures, model_ptr;
  int gen_cnt;
  int gen_lat = 2;
  int dup_req = 0;
  int dup_used = 0;

  always #5 clk = ~clk;

  ranperm_scheduler #(.N(N), .R(R)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .grant(grant),
    .idx_data(idx_data), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .idx_last(idx_last), .gen_reset(gen_reset), .gen_enable(gen_enable),
    .gen_rand_index(gen_rand_index), .gen_done(gen_done),
    .busy(busy), .perm_err(perm_err)
  );

  // Random permutation by Fisher-Yates; optionally corrupted with a duplicate.
  function automatic logic [N*W-1:0] make_perm(input bit dup);
    int a[N];
    int j, t;
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) a[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(a[i]);
    if (dup) r[W +: W] = r[0 +: W];
    return r;
  endfunction

  // Generator model: cleared by gen_reset, finishes after a random number of
  // enabled cycles and holds gen_done until the next gen_reset.
  assign gen_rand_index = gen_perm;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen_done <= 1'b0;
      gen_cnt  <= 0;
      gen_perm <= '0;
    end else if (gen_reset) begin
      gen_done <= 1'b0;
      gen_cnt  <= 0;
      gen_lat  <= int'($urandom_range(1, 4));
    end else if (gen_enable && !gen_done) begin
      if (gen_cnt >= gen_lat) begin
        gen_perm <= make_perm(dup_req != dup_used);
        if (dup_req != dup_used) dup_used <= dup_used + 1;
        gen_done <= 1'b1;
      end
      gen_cnt <= gen_cnt + 1;
    end
  end

  function automatic int rr_pick(input logic [R-1:0] m, input int ptr);
    logic [R-1:0] s;
    for (int i = 0; i < R; i++) begin
      s = m >> ((ptr + i) % R);
      if (s[0]) return (ptr + i) % R;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_grant"},      int'(grant),      0);
    check({tag, "_idx_valid"},  int'(idx_valid),  0);
    check({tag, "_idx_last"},   int'(idx_last),   0);
    check({tag, "_idx_data"},   int'(idx_data),   0);
    check({tag, "_gen_enable"}, int'(gen_enable), 0);
    check({tag, "_gen_reset"},  int'(gen_reset),  1);
    check({tag, "_busy"},       int'(busy),       0);
    check({tag, "_perm_err"},   int'(perm_err),   0);
  endtask

  // One transaction: request, expect the grant, drive ready per mode and
  // check the stream. kind selects an early stop (req drop or reset) after
  // stop_at handshakes.
  task automatic serve(input logic [R-1:0] mask, input int exp_g, input int mode,
                       input int kind, input int stop_at, input int exp_cycles,
                       input int exp_rej);
    logic [R-1:0] gbit;
    logic [W-1:0] got[$];
    logic [W-1:0] prev_data;
    logic [N-1:0] seenv;
    bit prev_stall, ready_now, finished;
    int waited, cyc, vcyc, hs, err_pulses, clr_pulses, done_cyc, first_valid;
    gbit = R'(1) << exp_g;
    prev_stall = 0; finished = 0; prev_data = '0;
    cyc = 0; vcyc = 0; hs = 0; err_pulses = 0; clr_pulses = 0;
    done_cyc = -100; first_valid = -1;
    req = mask;
    @(negedge clk);
    waited = 0;
    while (grant == '0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("grant", int'(grant), int'(gbit));
    check("grant_latency", waited, 0);
    if (grant == '0) return;
    while (!finished && cyc < 400) begin
      if (cyc == 0) begin
        check("clear_gen_reset", int'(gen_reset), 1);
        check("clear_gen_enable", int'(gen_enable), 0);
        check("busy", int'(busy), 1);
      end
      if (cyc == 1) begin
        check("gen_enable", int'(gen_enable), 1);
        check("gen_reset_low", int'(gen_reset), 0);
      end
      if (perm_err) err_pulses++;
      if (gen_reset) clr_pulses++;
      if (gen_enable && gen_done) done_cyc = cyc;
      idx_ready = R'($urandom);
      if (idx_valid) begin
        vcyc++;
        if (first_valid < 0) first_valid = cyc;
        if (kind == K_DROP && hs == stop_at) begin
          req = req & ~gbit;
          idx_ready = '0;
          finished = 1;
        end else if (kind == K_RESET && hs == stop_at) begin
          reset_n = 1'b0;
          #1;
          check_reset_values("midreset");
          idx_ready = '0;
          req = '0;
          finished = 1;
        end else begin
          if (prev_stall) check("stall_stable", int'(idx_data), int'(prev_data));
          check("idx_last", int'(idx_last), (hs == N - 1) ? 1 : 0);
          case (mode)
            M_HIGH:   ready_now = 1;
            M_TOGGLE: ready_now = (vcyc % 2 == 0);
            default:  ready_now = ($urandom_range(0, 1) != 0);
          endcase
          if (ready_now) begin
            idx_ready = idx_ready | gbit;
            check("idx_data", int'(idx_data), int'(gen_perm[hs*W +: W]));
            got.push_back(idx_data);
            hs++;
            if (hs == N) finished = 1;
          end else begin
            idx_ready = idx_ready & ~gbit;
          end
          prev_stall = !ready_now;
          prev_data = idx_data;
        end
      end else begin
        prev_stall = 0;
      end
      @(negedge clk);
      cyc++;
    end
    check("stream_done", int'(finished), 1);
    if (kind == K_RESET) begin
      reset_n = 1'b1;
      @(negedge clk);
      check("gen_reset_after_release", int'(gen_reset), 0);
      check("busy_after_release", int'(busy), 0);
      return;
    end
    check("end_grant", int'(grant), 0);
    check("end_valid", int'(idx_valid), 0);
    check("end_busy", int'(busy), 0);
    if (kind == K_NONE) begin
      check("handshakes", hs, N);
      seenv = '0;
      foreach (got[i]) seenv[got[i]] = 1'b1;
      check("distinct", int'(&seenv), 1);
      if (exp_cycles > 0) check("valid_cycles", vcyc, exp_cycles);
      check("perm_err_pulses", err_pulses, exp_rej);
      check("gen_reset_pulses", clr_pulses, 1 + exp_rej);
      check("done_to_valid", first_valid - done_cyc, LAT);
    end
  endtask

  typedef struct {
    logic [R-1:0] req;
    int           exp_g;
    int           mode;
    int           cycles;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [R-1:0] m;
    int g;
    tbl[0] = '{4'b0001, 0, M_HIGH,   16};
    tbl[1] = '{4'b1111, 1, M_HIGH,   16};
    tbl[2] = '{4'b1111, 2, M_HIGH,   16};
    tbl[3] = '{4'b1111, 3, M_HIGH,   16};
    tbl[4] = '{4'b1111, 0, M_HIGH,   16};
    tbl[5] = '{4'b1111, 1, M_TOGGLE, 32};
    tbl[6] = '{4'b1001, 3, M_HIGH,   16};
    tbl[7] = '{4'b1001, 0, M_TOGGLE, 32};
    tbl[8] = '{4'b0110, 1, M_RAND,   -1};

    checks = 0; failures = 0; model_ptr = 0;
    reset_n = 1'b0; req = '0; idx_ready = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("gen_reset_release", int'(gen_reset), 0);

    for (int v = 0; v < 9; v++) begin
      serve(tbl[v].req, tbl[v].exp_g, tbl[v].mode, K_NONE, 0, tbl[v].cycles, 0);
      model_ptr = (tbl[v].exp_g + 1) % R;
    end

    // Abort requester 0 after 5 handshakes; pending requester 1 follows.
    serve(4'b0011, rr_pick(4'b0011, model_ptr), M_HIGH, K_DROP, 5, -1, 0);
    model_ptr = 1;
    serve(4'b0010, rr_pick(4'b0010, model_ptr), M_HIGH, K_NONE, 0, 16, 0);
    model_ptr = 2;

`ifdef RANPERM_CHECK_EN
    dup_req++;
    serve(4'b0100, rr_pick(4'b0100, model_ptr), M_HIGH, K_NONE, 0, 16, 1);
    model_ptr = 3;
`endif

    for (int k = 0; k < 10; k++) begin
      m = R'($urandom_range(1, (1 << R) - 1));
      g = rr_pick(m, model_ptr);
      serve(m, g, M_RAND, K_NONE, 0, -1, 0);
      model_ptr = (g + 1) % R;
    end

    // Reset during STREAM; priority restarts at requester 0.
    serve(4'b1000, rr_pick(4'b1000, model_ptr), M_HIGH, K_RESET, 3, -1, 0);
    model_ptr = 0;
    serve(4'b1111, rr_pick(4'b1111, model_ptr), M_HIGH, K_NONE, 0, 16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
